multi_port_fifo: RTL and testbench

Parametrised multi-lane-write, single-lane-read circular FIFO, the next generation of the PE's tri-ported result FIFO. Each cycle a producer can push 0 to NUM_WR entries from lane-packed inputs. The consumer pops one entry per cycle through a registered output with a valid strobe. Compared with the tri-ported FIFO, this block adds true occupancy tracking, wrap-around at any DEPTH, all-or-nothing write admission and explicit accept/reject status.

---
 rtl/multi_port_fifo.sv | 128 ++++++++++++
 tb/tb_multi_port_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_fifo.sv
// Multi-lane-write, single-lane-read circular FIFO with all-or-nothing write
// admission, registered pop output and registered accept/reject status.

module multi_port_fifo_lane #(
    parameter int DEPTH = 24,
    parameter int LANE  = 0,
    parameter int AW    = 5,
    parameter int CW    = 5,
    parameter int NW    = 2
) (
    input  logic [AW-1:0] write_ptr,
    input  logic [NW-1:0] wr_count,
    input  logic          accept,
    output logic [AW-1:0] addr,
    output logic          en
);
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    logic [CW:0] sum;

    // write_ptr < DEPTH and LANE < DEPTH, so one conditional subtract is enough
    assign sum  = (CW+1)'(write_ptr) + (CW+1)'(LANE);
    assign addr = (sum >= DEPTH_X) ? AW'(sum - DEPTH_X) : AW'(sum);
    assign en   = accept && ((CW+1)'(wr_count) > (CW+1)'(LANE));
endmodule

module multi_port_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 24,
    parameter int NUM_WR = 3,
    parameter int CW     = $clog2(DEPTH+1),
    parameter int NW     = $clog2(NUM_WR+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WR*WIDTH-1:0] data_in,
    input  logic [NW-1:0]           wr_count,
    input  logic                    read,
    output logic [WIDTH-1:0]        data_out,
    output logic                    data_valid,
    output logic                    wr_ack,
    output logic                    wr_reject,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [CW-1:0]           count,
    output logic [CW-1:0]           free_slots
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    write_ptr, read_ptr;
    logic [CW-1:0]    count_q;

    logic [CW:0]      wr_count_x, free_x, wp_sum, rp_sum, cnt_sum;
    logic             accept, pop;
    logic [AW-1:0]    wp_nxt, rp_nxt;

    logic [AW-1:0]    lane_addr [NUM_WR];
    logic [NUM_WR-1:0] lane_en;

    assign count      = count_q;
    assign free_slots = CW'(DEPTH) - count_q;
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Admission sees the pre-pop free space: a same-cycle pop never makes room
    assign wr_count_x = (CW+1)'(wr_count);
    assign free_x     = (CW+1)'(free_slots);
    assign accept     = (wr_count != '0) && (wr_count_x <= (CW+1)'(NUM_WR)) &&
                        (wr_count_x <= free_x);
    assign pop        = read && (count_q != '0);

    assign wp_sum  = (CW+1)'(write_ptr) + wr_count_x;
    assign wp_nxt  = (wp_sum >= DEPTH_X) ? AW'(wp_sum - DEPTH_X) : AW'(wp_sum);
    assign rp_sum  = (CW+1)'(read_ptr) + (CW+1)'(1);
    assign rp_nxt  = (rp_sum >= DEPTH_X) ? AW'(rp_sum - DEPTH_X) : AW'(rp_sum);
    assign cnt_sum = (CW+1)'(count_q) + (accept ? wr_count_x : '0) - (CW+1)'(pop);

    for (genvar g = 0; g < NUM_WR; g++) begin : g_lane
        multi_port_fifo_lane #(
            .DEPTH (DEPTH),
            .LANE  (g),
            .AW    (AW),
            .CW    (CW),
            .NW    (NW)
        ) u_lane (
            .write_ptr (write_ptr),
            .wr_count  (wr_count),
            .accept    (accept),
            .addr      (lane_addr[g]),
            .en        (lane_en[g])
        );
    end

    // Storage is never reset; after a reset its stale contents are unreachable
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (lane_en[k])
                    mem[lane_addr[k]] <= data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_ptr  <= '0;
            read_ptr   <= '0;
            count_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            wr_ack     <= 1'b0;
            wr_reject  <= 1'b0;
        end else begin
            if (accept)
                write_ptr <= wp_nxt;
            if (pop) begin
                read_ptr <= rp_nxt;
                data_out <= mem[read_ptr];
            end
            count_q    <= CW'(cnt_sum);
            data_valid <= pop;
            wr_ack     <= accept;
            wr_reject  <= (wr_count != '0) && !accept;
        end
    end
endmodule

// File: tb/tb_multi_port_fifo.sv
// Scenario bench for multi_port_fifo against a queue-based reference model.

module tb_multi_port_fifo;
    localparam int WIDTH  = 64;
    localparam int DEPTH  = 24;
    localparam int NUM_WR = 3;
    localparam int CW     = $clog2(DEPTH+1);
    localparam int NW     = $clog2(NUM_WR+1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_WR*WIDTH-1:0] data_in;
    logic [NW-1:0]           wr_count;
    logic                    read;
    logic [WIDTH-1:0]        data_out;
    logic                    data_valid, wr_ack, wr_reject, fifo_full, fifo_empty;
    logic [CW-1:0]           count, free_slots;

    multi_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WR(NUM_WR)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_count(wr_count), .read(read),
        .data_out(data_out), .data_valid(data_valid), .wr_ack(wr_ack),
        .wr_reject(wr_reject), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .count(count), .free_slots(free_slots)
    );

    always #5 clk = ~clk;

    // reference model
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout;
    bit               exp_valid, exp_ack, exp_rej;
    int               m_wp, m_rp;
    int               n_checks = 0, n_pass = 0;

    function automatic logic [NUM_WR*WIDTH-1:0] rnd_lanes();
        logic [NUM_WR*WIDTH-1:0] v;
        for (int k = 0; k < NUM_WR; k++) v[k*WIDTH +: WIDTH] = {$urandom, $urandom};
        return v;
    endfunction

    // one clock: drive, take the edge, update model, settle for sampling
    task automatic step(input int n, input logic [NUM_WR*WIDTH-1:0] d, input bit rd, input bit r);
        int free;
        bit acc, popv;
        rst = r; wr_count = NW'(n); data_in = d; read = rd;
        free = DEPTH - q.size();
        acc  = (n > 0) && (n <= NUM_WR) && (n <= free);
        popv = rd && (q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete(); exp_dout = '0; exp_valid = 0; exp_ack = 0; exp_rej = 0;
            m_wp = 0; m_rp = 0;
        end else begin
            if (popv) begin exp_dout = q.pop_front(); m_rp = (m_rp + 1) % DEPTH; end
            if (acc) begin
                for (int k = 0; k < n; k++) q.push_back(d[k*WIDTH +: WIDTH]);
                m_wp = (m_wp + n) % DEPTH;
            end
            exp_valid = popv; exp_ack = acc; exp_rej = (n > 0) && !acc;
        end
        rst = 0; wr_count = '0; read = 0;
    endtask

    task automatic fill(input int n);
        while (n > 0) begin
            int c = (n >= NUM_WR) ? NUM_WR : n;
            step(c, rnd_lanes(), 0, 0);
            n -= c;
        end
    endtask

    task automatic test_reset();
        step(0, '0, 0, 1);
        n_checks++; if (count !== 0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", fifo_empty); else n_pass++;
        n_checks++; if (fifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", fifo_full); else n_pass++;
        n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", data_valid); else n_pass++;
        n_checks++; if (free_slots !== CW'(DEPTH)) $display("FAIL reset_free got %0d want %0d", free_slots, DEPTH); else n_pass++;
        n_checks++; if ({wr_ack, wr_reject} !== 2'b00) $display("FAIL reset_status got %b want 00", {wr_ack, wr_reject}); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL reset_dout got %h want 0", data_out); else n_pass++;
    endtask

    task automatic test_basic();
        step(1, (NUM_WR*WIDTH)'(64'hA), 0, 0);
        n_checks++; if (wr_ack !== 1'b1 || count !== 1) $display("FAIL basic_push ack=%b count=%0d want ack=1 count=1", wr_ack, count); else n_pass++;
        step(0, '0, 1, 0);
        n_checks++; if (data_valid !== 1'b1 || data_out !== 64'hA) $display("FAIL basic_pop valid=%b dout=%h want 1/a", data_valid, data_out); else n_pass++;
        n_checks++; if (count !== 0) $display("FAIL basic_count got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_multi_lane();
        logic [WIDTH-1:0] want [5] = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55};
        step(3, {64'h33, 64'h22, 64'h11}, 0, 0);
        n_checks++; if (count !== 3) $display("FAIL ml_count3 got %0d want 3", count); else n_pass++;
        step(2, {64'hDEAD, 64'h55, 64'h44}, 0, 0);
        n_checks++; if (count !== 5) $display("FAIL ml_count5 got %0d want 5", count); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1, 0);
            n_checks++; if (data_valid !== 1'b1 || data_out !== want[i]) $display("FAIL ml_pop%0d valid=%b dout=%h want 1/%h", i, data_valid, data_out, want[i]); else n_pass++;
        end
        n_checks++; if (count !== 0) $display("FAIL ml_count0 got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_full();
        step(0, '0, 0, 1);
        fill(22);
        n_checks++; if (count !== 22) $display("FAIL full_fill got %0d want 22", count); else n_pass++;
        step(3, rnd_lanes(), 0, 0);
        n_checks++; if (wr_reject !== 1'b1 || wr_ack !== 1'b0 || count !== 22) $display("FAIL full_rej3 rej=%b ack=%b count=%0d want 1/0/22", wr_reject, wr_ack, count); else n_pass++;
        step(2, rnd_lanes(), 0, 0);
        n_checks++; if (wr_ack !== 1'b1 || count !== 24 || fifo_full !== 1'b1) $display("FAIL full_ack2 ack=%b count=%0d full=%b want 1/24/1", wr_ack, count, fifo_full); else n_pass++;
        n_checks++; if (free_slots !== 0) $display("FAIL full_free got %0d want 0", free_slots); else n_pass++;
        step(1, rnd_lanes(), 0, 0);
        n_checks++; if (wr_reject !== 1'b1 || count !== 24) $display("FAIL full_rej1 rej=%b count=%0d want 1/24", wr_reject, count); else n_pass++;
        for (int i = 0; i < 24; i++) begin
            step(0, '0, 1, 0);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_dout) $display("FAIL full_drain%0d valid=%b dout=%h want 1/%h", i, data_valid, data_out, exp_dout); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        step(0, '0, 0, 1);
        fill(23);
        for (int i = 0; i < 23; i++) step(0, '0, 1, 0);
        n_checks++; if (dut.write_ptr !== 23 || dut.read_ptr !== 23) $display("FAIL wrap_ptrs wp=%0d rp=%0d want 23/23", dut.write_ptr, dut.read_ptr); else n_pass++;
        step(3, {64'h3, 64'h2, 64'h1}, 0, 0);
        n_checks++; if (dut.mem[23] !== 64'h1 || dut.mem[0] !== 64'h2 || dut.mem[1] !== 64'h3) $display("FAIL wrap_mem got %h %h %h want 1 2 3", dut.mem[23], dut.mem[0], dut.mem[1]); else n_pass++;
        n_checks++; if (dut.write_ptr !== 2) $display("FAIL wrap_wp got %0d want 2", dut.write_ptr); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step(0, '0, 1, 0);
            n_checks++; if (data_valid !== 1'b1 || data_out !== WIDTH'(i)) $display("FAIL wrap_pop%0d valid=%b dout=%h want 1/%0d", i, data_valid, data_out, i); else n_pass++;
            if (i == 1) begin
                n_checks++; if (dut.read_ptr !== 0) $display("FAIL wrap_rp got %0d want 0", dut.read_ptr); else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [CW-1:0] rp0;
        step(0, '0, 0, 1);
        fill(23);
        step(1, rnd_lanes(), 1, 0);
        n_checks++; if (wr_ack !== 1'b1 || count !== 23 || data_valid !== 1'b1) $display("FAIL sim_pp1 ack=%b count=%0d valid=%b want 1/23/1", wr_ack, count, data_valid); else n_pass++;
        step(2, rnd_lanes(), 1, 0);
        n_checks++; if (wr_reject !== 1'b1 || count !== 22) $display("FAIL sim_pp2 rej=%b count=%0d want 1/22", wr_reject, count); else n_pass++;
        step(0, '0, 0, 1);
        step(1, (NUM_WR*WIDTH)'(64'h77), 1, 0);
        n_checks++; if (data_valid !== 1'b0 || count !== 1 || wr_ack !== 1'b1) $display("FAIL sim_empty valid=%b count=%0d ack=%b want 0/1/1", data_valid, count, wr_ack); else n_pass++;
        step(0, '0, 1, 0);
        n_checks++; if (data_out !== 64'h77) $display("FAIL sim_nobypass dout=%h want 77", data_out); else n_pass++;
        rp0 = CW'(dut.read_ptr);
        step(0, '0, 1, 0);
        n_checks++; if (CW'(dut.read_ptr) !== rp0 || data_valid !== 1'b0 || count !== 0 || data_out !== 64'h77) $display("FAIL sim_rd_empty rp=%0d valid=%b dout=%h want %0d/0/77", dut.read_ptr, data_valid, data_out, rp0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(0, '0, 0, 1);
        fill(10);
        n_checks++; if (count !== 10) $display("FAIL rm_fill got %0d want 10", count); else n_pass++;
        step(2, rnd_lanes(), 1, 1);
        n_checks++; if (count !== 0 || fifo_empty !== 1'b1 || data_valid !== 1'b0 || wr_ack !== 1'b0) $display("FAIL rm_state count=%0d empty=%b valid=%b ack=%b want 0/1/0/0", count, fifo_empty, data_valid, wr_ack); else n_pass++;
        step(1, (NUM_WR*WIDTH)'(64'hBEEF), 0, 0);
        step(0, '0, 1, 0);
        n_checks++; if (data_valid !== 1'b1 || data_out !== 64'hBEEF || count !== 0) $display("FAIL rm_new valid=%b dout=%h count=%0d want 1/beef/0", data_valid, data_out, count); else n_pass++;
    endtask

    task automatic test_random();
        step(0, '0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            int n   = $urandom_range(0, NUM_WR);
            bit rd  = ($urandom_range(0, 99) < 45);
            bit r   = ($urandom_range(0, 199) == 0);
            step(n, rnd_lanes(), rd, r);
            n_checks++;
            if (count !== CW'(q.size()) || free_slots !== CW'(DEPTH - q.size()) ||
                fifo_full !== (q.size() == DEPTH) || fifo_empty !== (q.size() == 0) ||
                data_valid !== exp_valid || data_out !== exp_dout ||
                wr_ack !== exp_ack || wr_reject !== exp_rej)
                $display("FAIL rand_cyc%0d count=%0d/%0d valid=%b/%b dout=%h/%h ack=%b/%b rej=%b/%b full=%b empty=%b",
                         i, count, q.size(), data_valid, exp_valid, data_out, exp_dout,
                         wr_ack, exp_ack, wr_reject, exp_rej, fifo_full, fifo_empty);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1; wr_count = '0; data_in = '0; read = 0;
        exp_dout = '0; m_wp = 0; m_rp = 0;
        test_reset();
        test_basic();
        test_multi_lane();
        test_full();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
